sda_rx: RTL and testbench

SDA_RX -- requirements
Module: sda_rx

---
 rtl/sda_rx_pkg.sv | 14 +
 rtl/sda_rx_edge_det.sv | 45 ++++
 rtl/sda_rx.sv | 116 +++++++++++
 tb/tb_sda_rx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sda_rx_pkg.sv
// Shared serial-link definitions for the sda transmitter/receiver pair.
//   DW_DEFAULT : default payload width in bits
//   rx_state_t : receiver FSM state encoding
package sda_rx_pkg;

    localparam int unsigned DW_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SHIFT     = 2'b01,
        WAIT_STOP = 2'b10
    } rx_state_t;

endpackage

// File: rtl/sda_rx_edge_det.sv
// Two-stage synchroniser for scl/sda plus start, stop and scl-rise detection.
// Ports:
//   sclk    : system clock
//   rst     : synchronous active-high reset
//   scl/sda : asynchronous serial bus inputs, idle high
//   start   : sda fell while scl high
//   stop    : sda rose while scl high
//   rise    : scl rising edge
//   bit_val : sda value to sample on a rise
module sda_edge_det (
    input  logic sclk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic start,
    output logic stop,
    output logic rise,
    output logic bit_val
);

    logic scl_d, sda_d, scl_p, sda_p;

    // Reset to the idle-bus level so no false start/stop appears afterwards.
    always_ff @(posedge sclk) begin
        if (rst) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
            scl_p <= 1'b1;
            sda_p <= 1'b1;
        end else begin
            scl_d <= scl;
            sda_d <= sda;
            scl_p <= scl_d;
            sda_p <= sda_d;
        end
    end

    always_comb begin
        start   = scl_d & scl_p &  sda_p & ~sda_d;
        stop    = scl_d & scl_p & ~sda_p &  sda_d;
        rise    = ~scl_p & scl_d;
        bit_val = sda_d;
    end

endmodule

// File: rtl/sda_rx.sv
// Serial receiver: collects a DW-bit word (MSB first) framed by start/stop,
// presents it on data together with its one-hot decode on outh.
// Ports:
//   sclk      : system clock
//   rst       : synchronous active-high reset
//   scl, sda  : serial bus from the transmitter, idle high
//   data      : last correctly framed word
//   valid     : one-cycle pulse when data/outh are updated
//   outh      : one-hot decode of data
//   frame_err : one-cycle pulse on an aborted or malformed frame
module sda_rx
    import sda_rx_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             scl,
    input  logic             sda,
    output logic [DW-1:0]    data,
    output logic             valid,
    output logic [2**DW-1:0] outh,
    output logic             frame_err
);

    localparam int unsigned CW = $clog2(DW + 1);
    localparam int unsigned OW = 2**DW;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);
    localparam logic [OW-1:0] ONE  = OW'(1);

    logic start, stop, rise, bit_val;

    sda_edge_det u_edge (
        .sclk    (sclk),
        .rst     (rst),
        .scl     (scl),
        .sda     (sda),
        .start   (start),
        .stop    (stop),
        .rise    (rise),
        .bit_val (bit_val)
    );

    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] shreg;
    logic [DW-1:0] shreg_nxt;
    logic          stop_armed;

    always_comb begin
        shreg_nxt = (shreg << 1) | DW'(bit_val);
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            stop_armed <= 1'b0;
            data       <= '0;
            outh       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        cnt <= '0;
                    end else if (stop) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else if (rise) begin
                        shreg <= shreg_nxt;
                        cnt   <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            state      <= WAIT_STOP;
                            stop_armed <= 1'b0;
                        end
                    end
                end
                WAIT_STOP: begin
                    if (start) begin
                        frame_err <= 1'b1;
                        cnt       <= '0;
                        state     <= SHIFT;
                    end else if (stop) begin
                        data  <= shreg;
                        outh  <= ONE << shreg;
                        valid <= 1'b1;
                        state <= IDLE;
                    end else if (rise) begin
                        // A stop needs scl to come back high with sda low first;
                        // exactly one such rise is tolerated, any other rise is an
                        // extra data bit.
                        if (bit_val || stop_armed) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            stop_armed <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sda_rx.sv
module tb_sda_rx;

    localparam int unsigned DW = 4;
    localparam int unsigned OW = 2**DW;
    localparam int unsigned PH = 4;

    logic          sclk = 1'b0;
    logic          rst  = 1'b1;
    logic          scl  = 1'b1;
    logic          sda  = 1'b1;
    logic [DW-1:0] data;
    logic          valid;
    logic [OW-1:0] outh;
    logic          frame_err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    int n_err = 0;
    logic prev_valid = 1'b0;
    logic prev_err = 1'b0;
    logic [DW+OW-1:0] exp_q[$];
    logic [DW+OW-1:0] mon_e;

    always #5 sclk = ~sclk;

    sda_rx #(.DW(DW)) u_dut (
        .sclk      (sclk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .data      (data),
        .valid     (valid),
        .outh      (outh),
        .frame_err (frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge sclk) begin
        #1;
        if (valid) begin
            n_valid++;
            chk("valid_width", prev_valid, 0);
            chk("valid_and_err", frame_err, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", valid, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_data", data, mon_e[DW+OW-1:OW]);
                chk("sb_outh", outh, mon_e[OW-1:0]);
            end
        end
        if (frame_err) begin
            n_err++;
            chk("err_width", prev_err, 0);
        end
        prev_valid = valid;
        prev_err   = frame_err;
    end

    task automatic hold(input int unsigned n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic tx_start();
        sda = 1'b1; scl = 1'b1; hold(PH);
        sda = 1'b0; hold(PH);
        scl = 1'b0; hold(PH);
    endtask

    task automatic tx_rstart();
        sda = 1'b1; hold(PH);
        scl = 1'b1; hold(PH);
        sda = 1'b0; hold(PH);
        scl = 1'b0; hold(PH);
    endtask

    task automatic tx_bit(input logic b);
        sda = b;    hold(PH);
        scl = 1'b1; hold(PH);
        scl = 1'b0; hold(PH);
    endtask

    task automatic tx_stop(input logic expv);
        sda = 1'b0; hold(PH);
        scl = 1'b1; hold(PH);
        sda = 1'b1;
        @(posedge sclk); #1;
        chk("stop_lat_early", valid, 0);
        @(posedge sclk); #1;
        chk("stop_lat", valid, expv);
        hold(PH);
    endtask

    task automatic tx_bits(input logic [DW-1:0] w);
        logic [DW-1:0] t;
        t = w;
        for (int i = DW - 1; i >= 0; i--) tx_bit(t[i]);
    endtask

    task automatic good_frame(input logic [DW-1:0] w, input logic [OW-1:0] oh);
        tx_start();
        tx_bits(w);
        exp_q.push_back({w, oh});
        tx_stop(1'b1);
    endtask

    task automatic counts(input string tag, input int v0, input int e0, input int dv, input int de);
        chk({tag, "_valid_cnt"}, n_valid - v0, dv);
        chk({tag, "_err_cnt"},   n_err - e0,   de);
    endtask

    task automatic outs(input string tag, input logic [DW-1:0] d, input logic [OW-1:0] o);
        chk({tag, "_data"}, data, d);
        chk({tag, "_outh"}, outh, o);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int v0, e0;

        repeat (3) @(posedge sclk);
        #1;
        outs("reset", '0, '0);
        chk("reset_valid", valid, 0);
        chk("reset_err", frame_err, 0);
        @(negedge sclk);
        rst = 1'b0;
        hold(PH);

        // single frame 4'b1010
        v0 = n_valid; e0 = n_err;
        good_frame(4'hA, 16'h0400);
        counts("fa", v0, e0, 1, 0);
        outs("fa", 4'hA, 16'h0400);

        // back-to-back 0 then F
        v0 = n_valid; e0 = n_err;
        good_frame(4'h0, 16'h0001);
        good_frame(4'hF, 16'h8000);
        counts("b2b", v0, e0, 2, 0);
        outs("b2b", 4'hF, 16'h8000);

        // short frame aborted by stop
        v0 = n_valid; e0 = n_err;
        tx_start();
        tx_bit(1'b1);
        tx_bit(1'b0);
        tx_stop(1'b0);
        counts("short", v0, e0, 0, 1);
        outs("short", 4'hF, 16'h8000);

        // repeated start after two bits
        v0 = n_valid; e0 = n_err;
        tx_start();
        tx_bit(1'b1);
        tx_bit(1'b1);
        tx_rstart();
        tx_bits(4'h3);
        exp_q.push_back({4'h3, 16'h0008});
        tx_stop(1'b1);
        counts("rstart", v0, e0, 1, 0);
        outs("rstart", 4'h3, 16'h0008);

        // reset mid-frame, then a full frame
        v0 = n_valid; e0 = n_err;
        tx_start();
        tx_bit(1'b1);
        tx_bit(1'b1);
        tx_bit(1'b0);
        rst = 1'b1;
        @(posedge sclk); #1;
        outs("midrst", '0, '0);
        chk("midrst_valid", valid, 0);
        chk("midrst_err", frame_err, 0);
        @(negedge sclk);
        rst = 1'b0;
        hold(PH);
        counts("midrst", v0, e0, 0, 0);
        v0 = n_valid; e0 = n_err;
        good_frame(4'h5, 16'h0020);
        counts("after_rst", v0, e0, 1, 0);
        outs("after_rst", 4'h5, 16'h0020);

        // five bits: error on the fifth rise
        v0 = n_valid; e0 = n_err;
        tx_start();
        tx_bits(4'b1011);
        counts("long4", v0, e0, 0, 0);
        tx_bit(1'b1);
        counts("long5", v0, e0, 0, 1);
        tx_stop(1'b0);
        counts("long", v0, e0, 0, 1);
        outs("long", 4'h5, 16'h0020);

        hold(PH);
        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
